jk_ubus_slave_mem: RTL

JK_UBUS_SLAVE_MEM -- requirements
Module: jk_ubus_slave_mem

---
 rtl/jk_ubus_slave_mem_if.sv | 25 ++
 rtl/jk_ubus_slave_mem.sv | 106 ++++++++++
 2 files changed

// File: rtl/jk_ubus_slave_mem_if.sv
// Bus-side signals of the UBUS slave memory, grouped so master and slave
// can be connected through modports.
interface jk_ubus_slave_mem_if;
  logic [15:0] addr;
  logic [1:0]  size;
  logic        read;
  logic        write;
  logic        bip;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        wait_state;
  logic        error;
  logic        proto_err;

  modport master (
    output addr, size, read, write, bip, data_in,
    input  data_out, data_oe, wait_state, error, proto_err
  );

  modport slave (
    input  addr, size, read, write, bip, data_in,
    output data_out, data_oe, wait_state, error, proto_err
  );
endinterface

// File: rtl/jk_ubus_slave_mem.sv
// 256-byte UBUS slave memory with programmable wait states, burst support,
// an error response outside the decoded window and a sticky protocol flag.
module jk_ubus_slave_mem #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic                clk,
  input logic                reset,
  jk_ubus_slave_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, ERR} state_e;

  localparam logic [1:0] WAIT_INIT = 2'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [3:0]  beats_q, beats_d;
  logic [1:0]  wait_q, wait_d;
  logic        dir_q, dir_d;
  logic        proto_q, proto_d;
  logic [7:0]  mem_q [256];
  logic [7:0]  mem_d [256];

  logic [7:0]  data_out;
  logic        data_oe;
  logic        wait_state;
  logic        error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 8'h00;
      beats_q <= 4'd0;
      wait_q  <= 2'd0;
      dir_q   <= 1'b0;
      proto_q <= 1'b0;
      for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      dir_q   <= dir_d;
      proto_q <= proto_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    beats_d    = beats_q;
    wait_d     = wait_q;
    dir_d      = dir_q;
    proto_d    = proto_q;
    mem_d      = mem_q;
    data_out   = 8'h00;
    data_oe    = 1'b0;
    wait_state = 1'b0;
    error      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.read && bus.write) begin
          proto_d = 1'b1;
        end else if (bus.read || bus.write) begin
          ptr_d   = bus.addr[7:0];
          beats_d = 4'd1 << bus.size;
          dir_d   = bus.write;
          wait_d  = WAIT_INIT;
          state_d = (bus.addr[15:8] == BASE_ADDR[15:8]) ? DATA : ERR;
        end
      end

      DATA, ERR: begin
        if (bus.read || bus.write) proto_d = 1'b1;
        // Waits only apply inside the window; ERR answers every cycle.
        if (state_q == DATA && wait_q != 2'd0) begin
          wait_state = 1'b1;
          wait_d     = wait_q - 2'd1;
        end else begin
          error = (state_q == ERR);
          if (dir_q) begin
            if (state_q == DATA) mem_d[ptr_q] = bus.data_in;
          end else begin
            data_oe  = 1'b1;
            data_out = (state_q == DATA) ? mem_q[ptr_q] : 8'h00;
          end
          if (bus.bip != (beats_q > 4'd1)) proto_d = 1'b1;
          ptr_d   = ptr_q + 8'd1;
          beats_d = beats_q - 4'd1;
          wait_d  = WAIT_INIT;
          if (beats_q == 4'd1) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out   = data_out;
  assign bus.data_oe    = data_oe;
  assign bus.wait_state = wait_state;
  assign bus.error      = error;
  assign bus.proto_err  = proto_q;
endmodule
